mini_alu: RTL and testbench

- Top-level board block: receives PS/2 keyboard scancodes, shows the last make code on 8 LEDs, and drives a 640x480@60Hz VGA monitor with a 3-bit RGB colour.
- Keyboard keys R, G and B each toggle one colour bit of a colour register.
- The visible VGA area is filled with that colour.
- Single clock domain; PS/2 inputs are asynchronous and are synchronised internally.

---
 rtl/mini_alu.sv | 184 ++++++++++++++++++
 tb/tb_mini_alu.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mini_alu.sv
`timescale 1ns/1ps
// mini_alu: PS/2 keyboard receiver driving an LED scancode display and a VGA colour fill.
// Keys R/G/B toggle the three colour bits painted over the whole visible 640x480 area.
module mini_alu #(
  parameter int PIX_DIV     = 2,
  parameter int H_VIS       = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_VIS       = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int PS2_TIMEOUT = 50000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] oLed,
  output logic       VGA_RED,
  output logic       VGA_GREEN,
  output logic       VGA_BLUE,
  output logic       VGA_HSYNC,
  output logic       VGA_VSYNC
);
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int H_W = $clog2(H_TOTAL);
  localparam int V_W = $clog2(V_TOTAL);
  localparam int D_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int T_W = $clog2(PS2_TIMEOUT + 1);

  localparam logic [H_W-1:0] H_LAST  = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_VIS_L = H_W'(H_VIS);
  localparam logic [H_W-1:0] H_SS    = H_W'(H_VIS + H_FP);
  localparam logic [H_W-1:0] H_SE    = H_W'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [V_W-1:0] V_LAST  = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_VIS_L = V_W'(V_VIS);
  localparam logic [V_W-1:0] V_SS    = V_W'(V_VIS + V_FP);
  localparam logic [V_W-1:0] V_SE    = V_W'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [D_W-1:0] PIX_LAST = D_W'(PIX_DIV - 1);
  localparam logic [T_W-1:0] TMO_LAST = T_W'(PS2_TIMEOUT - 1);

  function automatic logic odd_parity(input logic [8:0] bits);
    odd_parity = ^bits;
  endfunction

  function automatic logic frame_ok(input logic [10:0] frame);
    frame_ok = (frame[0] == 1'b0) && (frame[10] == 1'b1) && odd_parity(frame[9:1]);
  endfunction

  logic [1:0]     clk_sync_r;
  logic [1:0]     data_sync_r;
  logic           clk_prev_r;
  logic           fall_s;
  logic [9:0]     shift_r;
  logic [10:0]    frame_s;
  logic [3:0]     bit_cnt_r;
  logic [T_W-1:0] tmo_cnt_r;
  logic [7:0]     code_r;
  logic           code_vld_r;
  logic           brk_r;
  logic [2:0]     colour_r;
  logic [D_W-1:0] pix_div_r;
  logic           pix_en_s;
  logic [H_W-1:0] hcount_r;
  logic [V_W-1:0] vcount_r;
  logic           hsync_s;
  logic           vsync_s;
  logic           vis_s;

  assign fall_s   = clk_prev_r & ~clk_sync_r[1];
  assign frame_s  = {data_sync_r[1], shift_r};
  assign pix_en_s = (pix_div_r == PIX_LAST);

  // Two-flop synchronisers for the asynchronous keyboard lines.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
      clk_prev_r  <= 1'b1;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], PS2_CLK};
      data_sync_r <= {data_sync_r[0], PS2_DATA};
      clk_prev_r  <= clk_sync_r[1];
    end
  end

  // Frame shifter; the 11th falling edge validates the frame, a long idle gap abandons it.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      shift_r    <= 10'd0;
      bit_cnt_r  <= 4'd0;
      tmo_cnt_r  <= '0;
      code_r     <= 8'd0;
      code_vld_r <= 1'b0;
    end else if (fall_s) begin
      tmo_cnt_r <= '0;
      if (bit_cnt_r == 4'd10) begin
        bit_cnt_r  <= 4'd0;
        code_r     <= frame_s[8:1];
        code_vld_r <= frame_ok(frame_s);
      end else begin
        bit_cnt_r  <= bit_cnt_r + 4'd1;
        shift_r    <= frame_s[10:1];
        code_vld_r <= 1'b0;
      end
    end else if (bit_cnt_r != 4'd0) begin
      code_vld_r <= 1'b0;
      if (tmo_cnt_r == TMO_LAST) begin
        bit_cnt_r <= 4'd0;
        tmo_cnt_r <= '0;
      end else begin
        tmo_cnt_r <= tmo_cnt_r + {{(T_W-1){1'b0}}, 1'b1};
      end
    end else begin
      code_vld_r <= 1'b0;
      tmo_cnt_r  <= '0;
    end
  end

  // Make/break decoding: a code following 0xF0 is a key release and is swallowed.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oLed     <= 8'd0;
      colour_r <= 3'b000;
      brk_r    <= 1'b0;
    end else if (code_vld_r) begin
      if (code_r == 8'hF0) begin
        brk_r <= 1'b1;
      end else if (brk_r) begin
        brk_r <= 1'b0;
      end else if (code_r != 8'hE0) begin
        oLed <= code_r;
        case (code_r)
          8'h2D:   colour_r[2] <= ~colour_r[2];
          8'h34:   colour_r[1] <= ~colour_r[1];
          8'h32:   colour_r[0] <= ~colour_r[0];
          default: colour_r    <= colour_r;
        endcase
      end
    end
  end

  // Pixel-rate divider and raster counters.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pix_div_r <= '0;
      hcount_r  <= '0;
      vcount_r  <= '0;
    end else if (pix_en_s) begin
      pix_div_r <= '0;
      if (hcount_r == H_LAST) begin
        hcount_r <= '0;
        vcount_r <= (vcount_r == V_LAST) ? '0 : vcount_r + {{(V_W-1){1'b0}}, 1'b1};
      end else begin
        hcount_r <= hcount_r + {{(H_W-1){1'b0}}, 1'b1};
      end
    end else begin
      pix_div_r <= pix_div_r + {{(D_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    hsync_s = !((hcount_r >= H_SS) && (hcount_r <= H_SE));
    vsync_s = !((vcount_r >= V_SS) && (vcount_r <= V_SE));
    vis_s   = (hcount_r < H_VIS_L) && (vcount_r < V_VIS_L);
  end

  // Every VGA output is registered from the same counter snapshot, one enable behind.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      VGA_HSYNC <= 1'b1;
      VGA_VSYNC <= 1'b1;
      {VGA_RED, VGA_GREEN, VGA_BLUE} <= 3'b000;
    end else if (pix_en_s) begin
      VGA_HSYNC <= hsync_s;
      VGA_VSYNC <= vsync_s;
      {VGA_RED, VGA_GREEN, VGA_BLUE} <= vis_s ? colour_r : 3'b000;
    end
  end

endmodule

// File: tb/tb_mini_alu.sv
`timescale 1ns/1ps
// tb_mini_alu: directed and randomized PS/2 keystrokes with a positional VGA reference model.
// A reduced raster and short PS/2 timeout keep the run short while exercising every boundary.
module tb_mini_alu;
  localparam int H_VIS = 16, H_FP = 2, H_SYNC = 4, H_BP = 3;
  localparam int V_VIS = 6, V_FP = 1, V_SYNC = 2, V_BP = 2;
  localparam int TMO = 200;
  localparam int HALF = 10;
  localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DATA = 1'b1;
  logic [7:0] oLed;
  logic       VGA_RED, VGA_GREEN, VGA_BLUE, VGA_HSYNC, VGA_VSYNC;

  int total = 0;
  int bad = 0;
  int n = 0;
  logic [7:0] m_led = 8'd0;
  logic [2:0] m_col = 3'b000;
  logic       m_brk = 1'b0;

  mini_alu #(
    .PIX_DIV(2), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .PS2_TIMEOUT(TMO)
  ) dut (
    .Clock(Clock), .Reset(Reset), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .oLed(oLed), .VGA_RED(VGA_RED), .VGA_GREEN(VGA_GREEN), .VGA_BLUE(VGA_BLUE),
    .VGA_HSYNC(VGA_HSYNC), .VGA_VSYNC(VGA_VSYNC)
  );

  always #10 Clock = ~Clock;

  // Clock edges since reset release: pixel k lands on edge 2k.
  always @(posedge Clock or negedge Reset) begin
    if (!Reset) n <= 0;
    else        n <= n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_vga(input string tag);
    int k, p, h, v;
    logic eh, ev;
    logic [2:0] ergb;
    k = n / 2;
    if (k == 0) begin
      eh = 1'b1; ev = 1'b1; ergb = 3'b000;
    end else begin
      p = (k - 1) % (HT * VT);
      h = p % HT;
      v = p / HT;
      eh = !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC);
      ev = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC);
      ergb = (h < H_VIS && v < V_VIS) ? m_col : 3'b000;
    end
    chk({tag, "_hsync"}, 32'(VGA_HSYNC), 32'(eh));
    chk({tag, "_vsync"}, 32'(VGA_VSYNC), 32'(ev));
    chk({tag, "_rgb"}, 32'({VGA_RED, VGA_GREEN, VGA_BLUE}), 32'(ergb));
  endtask

  task automatic run_vga(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge Clock);
      check_vga(tag);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] c, input logic bad_par);
    mk = {1'b1, (~(^c)) ^ bad_par, c, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] frame, input int nb);
    for (int i = 0; i < nb; i++) begin
      PS2_DATA = frame[i];
      repeat (HALF) @(negedge Clock);
      PS2_CLK = 1'b0;
      repeat (HALF) @(negedge Clock);
      PS2_CLK = 1'b1;
    end
    PS2_DATA = 1'b1;
    repeat (2 * HALF) @(negedge Clock);
  endtask

  // Keyboard-level meaning of one accepted scancode.
  task automatic model_key(input logic [7:0] c);
    if (c == 8'hF0) m_brk = 1'b1;
    else if (m_brk) m_brk = 1'b0;
    else if (c != 8'hE0) begin
      m_led = c;
      if (c == 8'h2D) m_col[2] = ~m_col[2];
      if (c == 8'h34) m_col[1] = ~m_col[1];
      if (c == 8'h32) m_col[0] = ~m_col[0];
    end
  endtask

  task automatic send_key(input string tag, input logic [7:0] c, input logic bad_par);
    send_bits(mk(c, bad_par), 11);
    if (!bad_par) model_key(c);
    chk({tag, "_led"}, 32'(oLed), 32'(m_led));
    run_vga(tag, 60);
  endtask

  initial begin
    logic [7:0] rc;
    int sel, hlow, vlow;

    #100;
    @(negedge Clock);
    Reset = 1'b1;
    check_vga("rst");
    chk("rst_led", 32'(oLed), 32'd0);
    run_vga("idle", 120);
    chk("idle_led", 32'(oLed), 32'd0);

    send_key("k2d", 8'h2D, 1'b0);
    send_key("brk_f0", 8'hF0, 1'b0);
    send_key("brk_2d", 8'h2D, 1'b0);
    send_key("k34", 8'h34, 1'b0);
    send_key("par32", 8'h32, 1'b1);
    send_key("k32", 8'h32, 1'b0);
    send_key("e0", 8'hE0, 1'b0);

    // Stop bit low: must be dropped.
    send_bits({1'b0, ~(^8'h34), 8'h34, 1'b0}, 11);
    chk("badstop_led", 32'(oLed), 32'(m_led));
    run_vga("badstop", 40);

    // Partial frame abandoned by the idle timeout.
    send_bits(mk(8'h2D, 1'b0), 5);
    repeat (TMO + 100) @(negedge Clock);
    send_key("tmo34", 8'h34, 1'b0);

    for (int i = 0; i < 10; i++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: rc = 8'h2D;
        1: rc = 8'h34;
        2: rc = 8'h32;
        3: rc = 8'hF0;
        4: rc = 8'hE0;
        default: rc = 8'($urandom);
      endcase
      send_key("rnd", rc, $urandom_range(0, 3) == 0);
    end

    // Reset in the middle of a PS/2 frame and a VGA frame.
    send_bits(mk(8'h34, 1'b0), 5);
    run_vga("pre_mrst", 37);
    Reset = 1'b0;
    m_led = 8'd0; m_col = 3'b000; m_brk = 1'b0;
    repeat (3) @(negedge Clock);
    chk("mrst_led", 32'(oLed), 32'd0);
    check_vga("mrst");
    Reset = 1'b1;
    run_vga("mrst_rel", 30);
    send_key("mrst32", 8'h32, 1'b0);
    send_key("mrst2d", 8'h2D, 1'b0);

    // Two whole frames: sync pulse widths measured independent of phase.
    hlow = 0; vlow = 0;
    for (int i = 0; i < 2 * HT * VT * 2; i++) begin
      @(negedge Clock);
      check_vga("frames");
      if (!VGA_HSYNC) hlow++;
      if (!VGA_VSYNC) vlow++;
    end
    chk("hsync_low_clks", 32'(hlow), 32'(2 * VT * H_SYNC * 2));
    chk("vsync_low_clks", 32'(vlow), 32'(2 * V_SYNC * HT * 2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
